// File: rtl/pattern_fifo_reader.sv
// -----------------------------------------------------------------------------
// pattern_fifo_reader
//
// Drains the 256-bit pattern FIFO, splits each word into eight 32-bit beats
// (bits 31:0 first) and streams them to the imager mask interface. Counts
// words per pattern and patterns per frame, and pulses pat_done / frame_done
// for the exposure control logic.
//
// Optional feature macro: PATTERN_ZERO_MASK_EN
//   defined   : after the last pattern, NUM_STREAMS*8 beats of 32'h0 are sent
//               (no FIFO reads, no pat_done), the final one carrying pat_last.
//   undefined : the last pattern goes straight to frame completion.
//
// Parameters
//   NUM_STREAMS  256-bit words per pattern (>= 1)
//   STALL_W      width of the saturating stall counter
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, Num_Pat    frame start pulse and patterns per frame (latched)
//   FIFO_dout         FIFO read data, valid the cycle after FIFO_rd_en
//   FIFO_empty        FIFO empty flag (only looked at while fetching)
//   FIFO_rd_en        FIFO read strobe (combinational)
//   pat_out/valid/ready/last   beat stream to the imager
//   pat_done          one-cycle pulse after each pattern's final beat
//   frame_done        one-cycle pulse at frame end
//   busy              high whenever the reader is not idle
//   stall_cnt         fetch cycles spent waiting on an empty FIFO (saturates)
//   o_state_dbg       current FSM state, for observation only
//
// Handshake: a beat transfers on a rising edge where pat_valid & pat_ready are
// both high; while pat_ready is low, pat_out, pat_valid and pat_last hold.
// -----------------------------------------------------------------------------
module pattern_fifo_reader #(
   parameter int NUM_STREAMS = 640,
   parameter int STALL_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [31:0]        Num_Pat,
   input  logic [255:0]       FIFO_dout,
   input  logic               FIFO_empty,
   output logic               FIFO_rd_en,
   output logic [31:0]        pat_out,
   output logic               pat_valid,
   input  logic               pat_ready,
   output logic               pat_last,
   output logic               pat_done,
   output logic               frame_done,
   output logic               busy,
   output logic [STALL_W-1:0] stall_cnt,
   output logic [2:0]         o_state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_SHIFT = 3'd3,
`ifdef PATTERN_ZERO_MASK_EN
      S_ZERO  = 3'd4,
`endif
      S_DONE  = 3'd5
   } state_t;

   state_t               r_state;
   logic [31:0]          r_num_pat;
   logic [31:0]          r_word_cnt;
   logic [31:0]          r_pat_cnt;
   logic [2:0]           r_beat;
   logic [255:0]         r_shift;
   logic                 r_pat_done;
   logic                 r_frame_done;
   logic [STALL_W-1:0]   r_stall_cnt;

   logic                 w_emitting;
   logic                 w_handshake;
   logic                 w_last_word;
   logic                 w_last_pat;
   logic [31:0]          w_beat_data;

`ifdef PATTERN_ZERO_MASK_EN
   assign w_emitting = (r_state == S_SHIFT) || (r_state == S_ZERO);
`else
   assign w_emitting = (r_state == S_SHIFT);
`endif

   assign w_handshake = w_emitting & pat_ready;
   assign w_last_word = (r_word_cnt == 32'(NUM_STREAMS - 1));
   assign w_last_pat  = (r_pat_cnt == (r_num_pat - 32'd1));
   // Beat b lives at bits [32*b +: 32]; {r_beat,5'd0} is 32*b.
   assign w_beat_data = r_shift[{r_beat, 5'd0} +: 32];

   assign FIFO_rd_en  = (r_state == S_FETCH) & ~FIFO_empty;
   assign pat_valid   = w_emitting;
   // Zero-mask beats also come out of the "not S_SHIFT" branch as 32'h0.
   assign pat_out     = (r_state == S_SHIFT) ? w_beat_data : 32'd0;
   assign pat_last    = w_emitting & (r_beat == 3'd7) & w_last_word;
   assign pat_done    = r_pat_done;
   assign frame_done  = r_frame_done;
   assign busy        = (r_state != S_IDLE);
   assign stall_cnt   = r_stall_cnt;
   assign o_state_dbg = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_num_pat    <= '0;
         r_word_cnt   <= '0;
         r_pat_cnt    <= '0;
         r_beat       <= '0;
         r_shift      <= '0;
         r_pat_done   <= 1'b0;
         r_frame_done <= 1'b0;
         r_stall_cnt  <= '0;
      end else begin
         r_pat_done   <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_num_pat   <= Num_Pat;
                  r_word_cnt  <= '0;
                  r_pat_cnt   <= '0;
                  r_stall_cnt <= '0;
                  r_state     <= (Num_Pat == 32'd0) ? S_DONE : S_FETCH;
               end
            end
            S_FETCH: begin
               if (!FIFO_empty) begin
                  r_state <= S_WAIT;
               end else if (r_stall_cnt != {STALL_W{1'b1}}) begin
                  r_stall_cnt <= r_stall_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               r_shift <= FIFO_dout;
               r_beat  <= 3'd0;
               r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               if (w_handshake) begin
                  // 3-bit index wraps 7 -> 0, ready for the next word.
                  r_beat <= r_beat + 3'd1;
                  if (r_beat == 3'd7) begin
                     if (w_last_word) begin
                        r_pat_done <= 1'b1;
                        r_word_cnt <= '0;
                        r_pat_cnt  <= r_pat_cnt + 32'd1;
`ifdef PATTERN_ZERO_MASK_EN
                        r_state    <= w_last_pat ? S_ZERO : S_FETCH;
`else
                        r_state    <= w_last_pat ? S_DONE : S_FETCH;
`endif
                     end else begin
                        r_word_cnt <= r_word_cnt + 32'd1;
                        r_state    <= S_FETCH;
                     end
                  end
               end
            end
`ifdef PATTERN_ZERO_MASK_EN
            S_ZERO: begin
               // Reuses beat/word counters to count NUM_STREAMS*8 zero beats.
               if (w_handshake) begin
                  r_beat <= r_beat + 3'd1;
                  if (r_beat == 3'd7) begin
                     if (w_last_word) begin
                        r_word_cnt <= '0;
                        r_state    <= S_DONE;
                     end else begin
                        r_word_cnt <= r_word_cnt + 32'd1;
                     end
                  end
               end
            end
`endif
            S_DONE: begin
               r_frame_done <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_pattern_fifo_reader
//
// Directed + randomised bench for pattern_fifo_reader (NUM_STREAMS=2,
// STALL_W=3 so that stall saturation is reachable). A simple FIFO model feeds
// the DUT; expected beats are derived from the words pushed into that FIFO:
// each frame takes Num_Pat*NUM_STREAMS words, each split low-beat-first, with
// pat_last on the final beat of every pattern (and of the zero block when
// PATTERN_ZERO_MASK_EN is defined).
// -----------------------------------------------------------------------------
module tb_pattern_fifo_reader;
   localparam int NS  = 2;
   localparam int SW  = 3;
   localparam int SAT = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [31:0]   Num_Pat;
   logic [255:0]  FIFO_dout = '0;
   logic          FIFO_empty;
   logic          FIFO_rd_en;
   logic [31:0]   pat_out;
   logic          pat_valid;
   logic          pat_ready;
   logic          pat_last;
   logic          pat_done;
   logic          frame_done;
   logic          busy;
   logic [SW-1:0] stall_cnt;
   logic [2:0]    state_dbg;

   pattern_fifo_reader #(.NUM_STREAMS(NS), .STALL_W(SW)) dut (
      .clk(clk), .rst(rst), .start(start), .Num_Pat(Num_Pat),
      .FIFO_dout(FIFO_dout), .FIFO_empty(FIFO_empty), .FIFO_rd_en(FIFO_rd_en),
      .pat_out(pat_out), .pat_valid(pat_valid), .pat_ready(pat_ready),
      .pat_last(pat_last), .pat_done(pat_done), .frame_done(frame_done),
      .busy(busy), .stall_cnt(stall_cnt), .o_state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- FIFO model ----------------
   logic [255:0] fifo_mem [64];
   int           wr_ptr = 0;
   int           rd_ptr = 0;
   bit           hold_empty = 1'b0;

   assign FIFO_empty = (wr_ptr == rd_ptr) || hold_empty;

   always @(posedge clk) begin
      if (FIFO_rd_en === 1'b1) begin
         FIFO_dout <= fifo_mem[rd_ptr % 64];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // ---------------- scoreboard state ----------------
   logic [31:0]  exp_q[$];
   bit           exp_last_q[$];
   bit           exp_pd_q[$];
   logic [255:0] model_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit start_req = 1'b0;
   int ready_mode = 0;
   int hold_rd = 0;
   int hold_len = 0;
   int stall_seen = 0;
   int beats_got, pd_cnt, fd_cnt, rd_cnt, busy_cyc;
   int last_acc, last_data_acc, fd_cyc, start_cyc;
   bit pd_due = 1'b0;
   bit prev_stall = 1'b0;
   bit prev_rd = 1'b0;
   logic [31:0] prev_out;
   logic        prev_last;
   logic [31:0] first_beat;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [255:0] w);
      fifo_mem[wr_ptr % 64] = w;
      wr_ptr++;
      model_q.push_back(w);
   endtask

   // One clock: drive inputs on the falling edge, sample #1 later.
   task automatic cycle();
      bit pd_next;
      @(negedge clk);
      cyc++;
      start     = start_req;
      start_req = 1'b0;
      case (ready_mode)
         0:       pat_ready = 1'b1;
         1:       pat_ready = (cyc % 2 == 0);
         default: pat_ready = 1'($urandom_range(0, 1));
      endcase
      hold_empty = (hold_rd > 0) && (rd_cnt >= hold_rd) && (stall_seen < hold_len);
      #1;
      if (prev_stall) begin
         chk("hold_valid", pat_valid, 1'b1);
         chk("hold_data", pat_out, prev_out);
         chk("hold_last", pat_last, prev_last);
      end
      chk("pat_done_timing", pat_done, pd_due);
      if (hold_empty) chk("rd_while_empty", FIFO_rd_en, 1'b0);
      if (hold_empty && busy && !pat_valid && !prev_rd) stall_seen++;
      pd_next = 1'b0;
      if (pat_valid && pat_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL extra_beat observed=%0h expected=none", pat_out);
         end else begin
            if (beats_got == 0) first_beat = pat_out;
            chk("beat_data", pat_out, exp_q.pop_front());
            chk("beat_last", pat_last, exp_last_q.pop_front());
            pd_next = exp_pd_q.pop_front();
            if (pd_next) last_data_acc = cyc;
            beats_got++;
            last_acc = cyc;
         end
      end
      pd_due = pd_next;
      if (FIFO_rd_en) rd_cnt++;
      if (pat_done) pd_cnt++;
      if (frame_done) begin
         fd_cnt++;
         fd_cyc = cyc;
      end
      if (busy) busy_cyc++;
      prev_stall = pat_valid && !pat_ready;
      prev_out   = pat_out;
      prev_last  = pat_last;
      prev_rd    = FIFO_rd_en;
   endtask

   // Build expectations from the FIFO contents, start a frame, run it to
   // frame_done and check the frame-level totals.
   task automatic run_frame(input int np, input int mode, input int h_rd,
                            input int h_len, input bit mid, input bit tput);
      logic [255:0] w;
      int exp_total;
      int n;
      bit mid_done;
      int exp_stall;
      for (int p = 0; p < np; p++) begin
         for (int k = 0; k < NS; k++) begin
            w = model_q.pop_front();
            for (int b = 0; b < 8; b++) begin
               exp_q.push_back(w[32*b +: 32]);
               exp_last_q.push_back((k == NS - 1) && (b == 7));
               exp_pd_q.push_back((k == NS - 1) && (b == 7));
            end
         end
      end
`ifdef PATTERN_ZERO_MASK_EN
      if (np > 0) begin
         for (int i = 0; i < NS * 8; i++) begin
            exp_q.push_back(32'd0);
            exp_last_q.push_back(i == NS * 8 - 1);
            exp_pd_q.push_back(1'b0);
         end
      end
`endif
      exp_total = exp_q.size();
      beats_got = 0; pd_cnt = 0; fd_cnt = 0; rd_cnt = 0; busy_cyc = 0;
      stall_seen = 0; fd_cyc = -1; last_acc = -1; last_data_acc = -1;
      hold_rd = h_rd; hold_len = h_len; ready_mode = mode; mid_done = 1'b0;
      Num_Pat = 32'(np);
      start_req = 1'b1;
      cycle();
      start_cyc = cyc;
      n = 0;
      while (fd_cnt == 0 && n < 3000) begin
         if (mid && !mid_done && beats_got == 5) begin
            start_req = 1'b1;
            Num_Pat   = $urandom;
            mid_done  = 1'b1;
         end
         cycle();
         n++;
      end
      if (fd_cnt == 0) begin
         checks++;
         errors++;
         $error("FAIL frame_timeout observed=no frame_done expected=frame_done within 3000 cycles");
      end
      repeat (3) cycle();
      hold_rd = 0;
      exp_stall = (h_len > SAT) ? SAT : h_len;
      chk("beat_count", beats_got, exp_total);
      chk("pat_done_count", pd_cnt, np);
      chk("frame_done_count", fd_cnt, 1);
      chk("fifo_reads", rd_cnt, np * NS);
      chk("frame_done_cycle", fd_cyc, (np == 0) ? start_cyc + 2 : last_acc + 2);
      chk("stall_cnt", stall_cnt, exp_stall);
      chk("busy_after", busy, 1'b0);
      if (np == 0) chk("busy_cycles", busy_cyc, 1);
      if (tput) chk("throughput", last_data_acc, start_cyc + 10 * NS * np);
      exp_q.delete();
      exp_last_q.delete();
      exp_pd_q.delete();
   endtask

   function automatic logic [255:0] byte_word(input int base);
      logic [255:0] w;
      for (int i = 0; i < 32; i++) w[8*i +: 8] = 8'(base + i);
      return w;
   endfunction

   function automatic logic [255:0] rand_word();
      logic [255:0] w;
      for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom;
      return w;
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      logic [255:0] w_abort;
      int n;
      rst = 1'b1; start = 1'b0; Num_Pat = '0; pat_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_rd_en", FIFO_rd_en, 1'b0);
      chk("rst_valid", pat_valid, 1'b0);
      chk("rst_out", pat_out, 32'd0);
      chk("rst_last", pat_last, 1'b0);
      chk("rst_pat_done", pat_done, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_stall", stall_cnt, '0);
      chk("rst_state", state_dbg, 3'd0);
      @(negedge clk);
      rst = 1'b0;

      // Byte-ramp frame, pat_ready held high.
      push_word(byte_word(0));
      push_word(byte_word(32));
      run_frame(1, 0, 0, 0, 1'b0, 1'b1);
      chk("first_beat", first_beat, 32'h03020100);

      // Same data, pat_ready toggling every cycle.
      push_word(byte_word(0));
      push_word(byte_word(32));
      run_frame(1, 1, 0, 0, 1'b0, 1'b0);
      chk("first_beat_toggle", first_beat, 32'h03020100);

      // Three patterns, FIFO held empty for 5 fetch cycles before word 3.
      for (int i = 0; i < 3 * NS; i++) push_word(rand_word());
      run_frame(3, 0, 2, 5, 1'b0, 1'b0);

      // Long stall: counter must saturate at all-ones.
      for (int i = 0; i < 2 * NS; i++) push_word(rand_word());
      run_frame(2, 0, 1, 9, 1'b0, 1'b0);

      // Zero patterns: straight to frame_done, no reads.
      run_frame(0, 0, 0, 0, 1'b0, 1'b0);

      // Random frames, random backpressure, ignored start mid-frame.
      for (int t = 0; t < 3; t++) begin
         int np;
         np = $urandom_range(1, 3);
         for (int i = 0; i < np * NS; i++) push_word(rand_word());
         run_frame(np, 2, 0, 0, 1'b1, 1'b0);
      end

      // Asynchronous reset while beat 3 of the first word is on the bus.
      push_word(rand_word());
      push_word(rand_word());
      w_abort = model_q.pop_front();
      for (int b = 0; b < 8; b++) begin
         exp_q.push_back(w_abort[32*b +: 32]);
         exp_last_q.push_back(1'b0);
         exp_pd_q.push_back(1'b0);
      end
      beats_got = 0; rd_cnt = 0; ready_mode = 0; hold_rd = 0;
      Num_Pat = 32'd1;
      start_req = 1'b1;
      cycle();
      n = 0;
      while (beats_got < 3 && n < 100) begin
         cycle();
         n++;
      end
      @(posedge clk);
      #2;
      chk("pre_rst_beat3", pat_out, w_abort[127:96]);
      rst = 1'b1;
      #1;
      chk("abort_valid", pat_valid, 1'b0);
      chk("abort_out", pat_out, 32'd0);
      chk("abort_last", pat_last, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_rd_en", FIFO_rd_en, 1'b0);
      chk("abort_frame_done", frame_done, 1'b0);
      chk("abort_reads", rd_cnt, 1);
      exp_q.delete();
      exp_last_q.delete();
      exp_pd_q.delete();
      pd_due = 1'b0;
      prev_stall = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push_word(rand_word());
      run_frame(1, 0, 0, 0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
